// File: rtl/wb_soc_pkg.sv
// Shared definitions for the Wishbone SoC register slave: register offsets,
// bit positions and the byte-lane merge helper.
package wb_soc_pkg;

    // Register offsets, decoded from ADR_I[3:2]
    typedef enum logic [1:0] {
        REG_ADDR   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_STATUS = 2'd2,
        REG_MASK   = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned STAT_PEND = 0;

    // Replace only the byte lanes whose SEL bit is set
    function automatic logic [31:0] lane_merge(input logic [31:0] old_data,
                                               input logic [31:0] new_data,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        merged = old_data;
        for (int unsigned n = 0; n < 4; n++) begin
            if (sel[n]) begin
                merged[8*n +: 8] = new_data[8*n +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_soc_reg_slave_irq.sv
// irq_edge_latch: rising-edge detector on raise_irq feeding a sticky pending
// flag. A new edge wins over a simultaneous clear so no event is lost.
module irq_edge_latch (
    input  logic p_clk,
    input  logic p_resetn,
    input  logic raise_irq,
    input  logic clear,
    output logic pend
);

    logic rq_d;
    logic set;

    assign set = raise_irq & ~rq_d;

    // Edge-detect delay stage and set-priority pending latch
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            rq_d <= 1'b0;
            pend <= 1'b0;
        end else begin
            rq_d <= raise_irq;
            if (set) begin
                pend <= 1'b1;
            end else if (clear) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_soc_reg_slave.sv
// wb_soc_reg_slave: Wishbone B3 classic register slave for the video module.
// Holds the frame base address, run enable and a sticky interrupt latch.
// Optional feature: define WB_SOC_SLAVE_IRQ_MASK_EN to add a R/W MASK bit at
// offset 3 that gates the irq output (PEND still latches while masked).
module wb_soc_reg_slave #(
    parameter logic [31:0] ADDR_RESET = 32'h4100_0000
) (
    input  logic        p_clk,
    input  logic        p_resetn,
    input  logic        raise_irq,
    output logic        irq,
    output logic [31:0] module_register,
    output logic        initialized,
    output logic        written,
    input  logic [31:0] p_wb_reg_DAT_I,
    output logic [31:0] p_wb_reg_DAT_O,
    input  logic [31:0] p_wb_reg_ADR_I,
    output logic        p_wb_reg_ACK_O,
    input  logic        p_wb_reg_CYC_I,
    output logic        p_wb_reg_ERR_O,
    input  logic        p_wb_reg_LOCK_I,
    output logic        p_wb_reg_RTY_O,
    input  logic [3:0]  p_wb_reg_SEL_I,
    input  logic        p_wb_reg_STB_I,
    input  logic        p_wb_reg_WE_I
);

    import wb_soc_pkg::*;

    logic        acc;
    logic        wr_acc;
    logic        rd_acc;
    reg_sel_e    reg_sel;
    logic        pend_clear;
    logic        pend;
    logic        mask_q;
    logic [31:0] rdata;
    logic        unused_inputs;

    assign acc     = p_wb_reg_CYC_I & p_wb_reg_STB_I & ~p_wb_reg_ACK_O;
    assign wr_acc  = acc & p_wb_reg_WE_I;
    assign rd_acc  = acc & ~p_wb_reg_WE_I;
    assign reg_sel = reg_sel_e'(p_wb_reg_ADR_I[3:2]);

    assign pend_clear = wr_acc && (reg_sel == REG_STATUS) &&
                        p_wb_reg_SEL_I[0] && p_wb_reg_DAT_I[STAT_PEND];

    assign p_wb_reg_ERR_O = 1'b0;
    assign p_wb_reg_RTY_O = 1'b0;

    assign unused_inputs = ^{p_wb_reg_ADR_I[31:4], p_wb_reg_ADR_I[1:0], p_wb_reg_LOCK_I};

    irq_edge_latch u_irq_latch (
        .p_clk     (p_clk),
        .p_resetn  (p_resetn),
        .raise_irq (raise_irq),
        .clear     (pend_clear),
        .pend      (pend)
    );

`ifdef WB_SOC_SLAVE_IRQ_MASK_EN
    // Interrupt mask bit, reset to unmasked
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            mask_q <= 1'b1;
        end else if (wr_acc && (reg_sel == REG_MASK) && p_wb_reg_SEL_I[0]) begin
            mask_q <= p_wb_reg_DAT_I[0];
        end
    end
`else
    assign mask_q = 1'b1;
`endif

    // Read-data mux; unmapped bits read zero
    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_ADDR:   rdata = module_register;
            REG_CTRL:   rdata[CTRL_EN] = written;
            REG_STATUS: rdata[STAT_PEND] = pend;
            REG_MASK: begin
`ifdef WB_SOC_SLAVE_IRQ_MASK_EN
                rdata[0] = mask_q;
`endif
            end
            default:    rdata = '0;
        endcase
    end

    // Bus handshake, register writes and registered read data
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            p_wb_reg_ACK_O  <= 1'b0;
            p_wb_reg_DAT_O  <= '0;
            module_register <= ADDR_RESET;
            initialized     <= 1'b0;
            written         <= 1'b0;
        end else begin
            p_wb_reg_ACK_O <= acc;
            if (rd_acc) begin
                p_wb_reg_DAT_O <= rdata;
            end
            if (wr_acc) begin
                unique case (reg_sel)
                    REG_ADDR: begin
                        module_register <= lane_merge(module_register, p_wb_reg_DAT_I,
                                                      p_wb_reg_SEL_I);
                        if (p_wb_reg_SEL_I != 4'b0000) begin
                            initialized <= 1'b1;
                        end
                    end
                    REG_CTRL: begin
                        if (p_wb_reg_SEL_I[0]) begin
                            written <= p_wb_reg_DAT_I[CTRL_EN];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered interrupt output; follows PEND one cycle later
    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            irq <= 1'b0;
        end else begin
            irq <= pend & mask_q;
        end
    end

endmodule

// File: tb/tb_wb_soc_reg_slave.sv
// Directed self-checking bench for wb_soc_reg_slave; read data is checked
// through an expected-value queue filled when each read is issued.
`timescale 1ns/1ps
module tb_wb_soc_reg_slave;

    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic        raise_irq = 1'b0;
    logic        irq;
    logic [31:0] module_register;
    logic        initialized;
    logic        written;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [31:0] adr = '0;
    logic        ack;
    logic        cyc = 1'b0;
    logic        err;
    logic        lock = 1'b0;
    logic        rty;
    logic [3:0]  sel = '0;
    logic        stb = 1'b0;
    logic        we = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q[$];

    always #5 p_clk = ~p_clk;

    wb_soc_reg_slave #(.ADDR_RESET(32'h4100_0000)) dut (
        .p_clk           (p_clk),
        .p_resetn        (p_resetn),
        .raise_irq       (raise_irq),
        .irq             (irq),
        .module_register (module_register),
        .initialized     (initialized),
        .written         (written),
        .p_wb_reg_DAT_I  (dat_i),
        .p_wb_reg_DAT_O  (dat_o),
        .p_wb_reg_ADR_I  (adr),
        .p_wb_reg_ACK_O  (ack),
        .p_wb_reg_CYC_I  (cyc),
        .p_wb_reg_ERR_O  (err),
        .p_wb_reg_LOCK_I (lock),
        .p_wb_reg_RTY_O  (rty),
        .p_wb_reg_SEL_I  (sel),
        .p_wb_reg_STB_I  (stb),
        .p_wb_reg_WE_I   (we)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    // Single write; checks ACK rises on the first edge and drops on the next
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d; sel = s;
        tick();
        check("ack_w_rise", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check("ack_w_fall", 32'(ack), 32'd0);
    endtask

    // Single read; expected data queued at issue, compared on the ack edge
    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] e;
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        exp_q.push_back(exp);
        tick();
        check("ack_r_rise", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("rdata", dat_o, e);
        end
        tick();
        check("ack_r_fall", 32'(ack), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rty", 32'(rty), 32'd0);
        check("rst_addr", module_register, 32'h4100_0000);
        check("rst_init", 32'(initialized), 32'd0);
        check("rst_en", 32'(written), 32'd0);
        p_resetn = 1'b1;
        tick();

        // Reset value readback and first address write
        wb_read(32'h0, 32'h4100_0000);
        check("init_before", 32'(initialized), 32'd0);
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_i = 32'h4000_1000; sel = 4'hF;
        #3;
        check("init_pre_edge", 32'(initialized), 32'd0);
        check("addr_pre_edge", module_register, 32'h4100_0000);
        tick();
        check("ack_addr", 32'(ack), 32'd1);
        check("addr_written", module_register, 32'h4000_1000);
        check("init_set", 32'(initialized), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check("ack_addr_fall", 32'(ack), 32'd0);

        // Byte-lane write
        wb_write(32'h0, 32'hAABB_CCDD, 4'b0101);
        check("addr_lanes", module_register, 32'h40BB_10DD);
        wb_read(32'h0, 32'h40BB_10DD);
        repeat (3) tick();
        check("dat_hold", dat_o, 32'h40BB_10DD);

        // SEL=0 write changes nothing
        wb_write(32'h0, 32'h1234_5678, 4'b0000);
        check("addr_sel0", module_register, 32'h40BB_10DD);

        // Enable bit and address aliasing
        wb_write(32'h4, 32'hFFFF_FFFF, 4'hF);
        check("en_set", 32'(written), 32'd1);
        wb_read(32'h4, 32'h1);
        wb_write(32'h4, 32'h0, 4'hF);
        check("en_clr", 32'(written), 32'd0);
        wb_read(32'h10, 32'h40BB_10DD);

        // Back-to-back with STB held: ACK alternates
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
        tick();
        check("b2b_ack0", 32'(ack), 32'd1);
        tick();
        check("b2b_ack1", 32'(ack), 32'd0);
        tick();
        check("b2b_ack2", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        tick();
        check("b2b_ack3", 32'(ack), 32'd0);

        // IRQ: edge latched, irq two edges after raise
        raise_irq = 1'b1;
        tick();
        check("irq_lat1", 32'(irq), 32'd0);
        tick();
        check("irq_lat2", 32'(irq), 32'd1);
        wb_read(32'h8, 32'h1);
        // Clear while raise_irq stays high
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; dat_i = 32'h1; sel = 4'h1;
        tick();
        check("irq_at_clear_ack", 32'(irq), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check("irq_cleared", 32'(irq), 32'd0);
        repeat (2) tick();
        check("irq_stays_low", 32'(irq), 32'd0);
        wb_read(32'h8, 32'h0);
        raise_irq = 1'b0;
        repeat (2) tick();

        // Writing 0 to STATUS does not clear
        raise_irq = 1'b1;
        repeat (2) tick();
        raise_irq = 1'b0;
        wb_write(32'h8, 32'h0, 4'hF);
        wb_read(32'h8, 32'h1);
        check("irq_w0_kept", 32'(irq), 32'd1);
        wb_write(32'h8, 32'h1, 4'h1);
        tick();
        check("irq_clr2", 32'(irq), 32'd0);

        // Simultaneous new edge and clear: set wins
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h8; dat_i = 32'h1; sel = 4'h1;
        raise_irq = 1'b1;
        tick();
        check("sim_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check("sim_irq", 32'(irq), 32'd1);
        wb_read(32'h8, 32'h1);
        raise_irq = 1'b0;
        wb_write(32'h8, 32'h1, 4'h1);
        tick();
        check("sim_irq_clr", 32'(irq), 32'd0);

`ifdef WB_SOC_SLAVE_IRQ_MASK_EN
        wb_read(32'hC, 32'h1);
        wb_write(32'hC, 32'h0, 4'h1);
        wb_read(32'hC, 32'h0);
        raise_irq = 1'b1;
        repeat (3) tick();
        raise_irq = 1'b0;
        check("mask_irq_low", 32'(irq), 32'd0);
        wb_read(32'h8, 32'h1);
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'hC; dat_i = 32'h1; sel = 4'h1;
        tick();
        check("unmask_ack_irq", 32'(irq), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check("unmask_irq", 32'(irq), 32'd1);
        wb_write(32'h8, 32'h1, 4'h1);
        tick();
        check("mask_irq_clr", 32'(irq), 32'd0);
`else
        wb_write(32'hC, 32'hFFFF_FFFF, 4'hF);
        wb_read(32'hC, 32'h0);
`endif

        // Reset mid-transfer aborts ACK and restores state
        tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
        tick();
        check("mid_ack", 32'(ack), 32'd1);
        p_resetn = 1'b0;
        #1;
        check("mid_ack_abort", 32'(ack), 32'd0);
        check("mid_addr", module_register, 32'h4100_0000);
        check("mid_init", 32'(initialized), 32'd0);
        check("mid_dat", dat_o, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        tick();
        p_resetn = 1'b1;
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
